// File: rtl/e203_exu_pkg.sv
// ---------------------------------------------------------------------------
// e203_exu_pkg
// Shared types and constants for the EXU long-pipe tracker.
//   ITAG_PORT_W   : width of itag ports (itags are zero-extended to this)
//   RIDX_W        : register index width
//   PC_W          : program counter width
//   DEFAULT_DEPTH : default number of outstanding long-pipe entries
//   oitf_entry_t  : one tracked instruction {vld, rdwen, rdfpu, rdidx, pc}
//   entry_hits()  : destination-register match of an entry vs. a register
// ---------------------------------------------------------------------------
package e203_exu_pkg;

    localparam int unsigned ITAG_PORT_W   = 5;
    localparam int unsigned RIDX_W        = 5;
    localparam int unsigned PC_W          = 32;
    localparam int unsigned DEFAULT_DEPTH = 2;

    typedef struct packed {
        logic              vld;
        logic              rdwen;
        logic              rdfpu;
        logic [RIDX_W-1:0] rdidx;
        logic [PC_W-1:0]   pc;
    } oitf_entry_t;

    // An in-flight entry conflicts with a register only if it will actually
    // write that register in the same register file.
    function automatic logic entry_hits(input oitf_entry_t       e,
                                        input logic [RIDX_W-1:0] idx,
                                        input logic              fpu);
        return e.vld & e.rdwen & (e.rdidx == idx) & (e.rdfpu == fpu);
    endfunction

endpackage

// File: rtl/e203_exu_wrap_ptr.sv
// ---------------------------------------------------------------------------
// e203_exu_wrap_ptr
// Circular pointer with a wrap flag. The flag toggles each time the pointer
// wraps from DEPTH-1 back to 0, so two pointers with equal values can be
// told apart as "empty" (flags equal) or "full" (flags differ).
//   clk  : clock
//   rst  : asynchronous active-high reset (pointer and flag to 0)
//   ena  : advance the pointer by one
//   ptr  : current pointer value
//   flag : current wrap flag
// ---------------------------------------------------------------------------
module e203_exu_wrap_ptr #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    output logic [W-1:0] ptr,
    output logic         flag
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] r_ptr;
    logic         r_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_flag <= 1'b0;
        end else if (ena) begin
            if (r_ptr == LAST) begin
                r_ptr  <= '0;
                r_flag <= ~r_flag;
            end else begin
                r_ptr  <= r_ptr + 1'b1;
            end
        end
    end

    assign ptr  = r_ptr;
    assign flag = r_flag;

endmodule

// File: rtl/e203_exu_longp_tracker.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_tracker
// Outstanding long-pipe instruction tracker (OITF). Allocates an itag per
// dispatched long-pipe instruction, keeps its rd/pc, presents the oldest
// entry to the write-back arbiter and flags RAW/WAW hazards of the
// dispatching instruction against every in-flight entry.
//   clk, rst                 : clock, asynchronous active-high reset
//   dis_ena/dis_ready/dis_ptr: allocation handshake and granted itag
//   dis_rd*/dis_pc           : destination metadata of the dispatching instr
//   dis_rsN*                 : source operands checked for dependence
//   dep_rs1..3, dep_rd       : RAW / WAW hazard flags
//   oitf_empty               : no entry in flight
//   oitf_ret_*               : itag and metadata of the oldest entry
//   oitf_ret_ena             : oldest entry retires
// ---------------------------------------------------------------------------
module e203_exu_longp_tracker
    import e203_exu_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned ITAG_W    = $clog2(DEPTH),
    parameter bit          ASSERT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dis_ena,
    output logic                   dis_ready,
    output logic [ITAG_PORT_W-1:0] dis_ptr,
    input  logic                   dis_rdwen,
    input  logic                   dis_rdfpu,
    input  logic [RIDX_W-1:0]      dis_rdidx,
    input  logic [PC_W-1:0]        dis_pc,
    input  logic                   dis_rs1en,
    input  logic                   dis_rs2en,
    input  logic                   dis_rs3en,
    input  logic                   dis_rs1fpu,
    input  logic                   dis_rs2fpu,
    input  logic                   dis_rs3fpu,
    input  logic [RIDX_W-1:0]      dis_rs1idx,
    input  logic [RIDX_W-1:0]      dis_rs2idx,
    input  logic [RIDX_W-1:0]      dis_rs3idx,
    output logic                   dep_rs1,
    output logic                   dep_rs2,
    output logic                   dep_rs3,
    output logic                   dep_rd,
    output logic                   oitf_empty,
    output logic [ITAG_PORT_W-1:0] oitf_ret_ptr,
    output logic [RIDX_W-1:0]      oitf_ret_rdidx,
    output logic [PC_W-1:0]        oitf_ret_pc,
    output logic                   oitf_ret_rdwen,
    output logic                   oitf_ret_rdfpu,
    input  logic                   oitf_ret_ena
);

    logic [ITAG_W-1:0] w_alc_ptr;
    logic [ITAG_W-1:0] w_ret_ptr;
    logic              w_alc_flag;
    logic              w_ret_flag;
    logic              w_empty;
    logic              w_full;
    logic              w_alc_fire;
    logic              w_ret_fire;
    logic              w_hit_rs1;
    logic              w_hit_rs2;
    logic              w_hit_rs3;
    logic              w_hit_rd;

    oitf_entry_t r_ent [DEPTH];

    assign w_empty    = (w_alc_ptr == w_ret_ptr) && (w_alc_flag == w_ret_flag);
    assign w_full     = (w_alc_ptr == w_ret_ptr) && (w_alc_flag != w_ret_flag);
    // Neither fire can happen in a state where the pointers coincide with the
    // other operation also firing, so alloc and retire never touch one slot.
    assign w_alc_fire = dis_ena & ~w_full;
    assign w_ret_fire = oitf_ret_ena & ~w_empty;

    e203_exu_wrap_ptr #(.W(ITAG_W), .DEPTH(DEPTH)) u_alc_ptr (
        .clk  (clk),
        .rst  (rst),
        .ena  (w_alc_fire),
        .ptr  (w_alc_ptr),
        .flag (w_alc_flag)
    );

    e203_exu_wrap_ptr #(.W(ITAG_W), .DEPTH(DEPTH)) u_ret_ptr (
        .clk  (clk),
        .rst  (rst),
        .ena  (w_ret_fire),
        .ptr  (w_ret_ptr),
        .flag (w_ret_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (w_ret_fire) begin
                r_ent[w_ret_ptr].vld <= 1'b0;
            end
            if (w_alc_fire) begin
                r_ent[w_alc_ptr] <= '{vld:   1'b1,
                                      rdwen: dis_rdwen,
                                      rdfpu: dis_rdfpu,
                                      rdidx: dis_rdidx,
                                      pc:    dis_pc};
            end
        end
    end

    // Hazards are evaluated on registered state only; the instruction
    // dispatching this cycle is not yet an entry.
    always_comb begin
        w_hit_rs1 = 1'b0;
        w_hit_rs2 = 1'b0;
        w_hit_rs3 = 1'b0;
        w_hit_rd  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_hit_rs1 = w_hit_rs1 | entry_hits(r_ent[i], dis_rs1idx, dis_rs1fpu);
            w_hit_rs2 = w_hit_rs2 | entry_hits(r_ent[i], dis_rs2idx, dis_rs2fpu);
            w_hit_rs3 = w_hit_rs3 | entry_hits(r_ent[i], dis_rs3idx, dis_rs3fpu);
            w_hit_rd  = w_hit_rd  | entry_hits(r_ent[i], dis_rdidx,  dis_rdfpu);
        end
    end

    assign dep_rs1 = dis_rs1en & w_hit_rs1;
    assign dep_rs2 = dis_rs2en & w_hit_rs2;
    assign dep_rs3 = dis_rs3en & w_hit_rs3;
    assign dep_rd  = dis_rdwen & w_hit_rd;

    assign dis_ready      = ~w_full;
    assign dis_ptr        = ITAG_PORT_W'(w_alc_ptr);
    assign oitf_empty     = w_empty;
    assign oitf_ret_ptr   = ITAG_PORT_W'(w_ret_ptr);
    assign oitf_ret_rdidx = r_ent[w_ret_ptr].rdidx;
    assign oitf_ret_pc    = r_ent[w_ret_ptr].pc;
    assign oitf_ret_rdwen = r_ent[w_ret_ptr].rdwen;
    assign oitf_ret_rdfpu = r_ent[w_ret_ptr].rdfpu;

    generate
        if (ASSERT_EN) begin : g_chk
            a_no_dis_when_full : assert property (
                @(posedge clk) disable iff (rst) !(dis_ena && w_full));
        end
    endgenerate

endmodule
